// File: rtl/lcd_fetch_sched_pkg.sv
// Shared constants, FSM encoding and helpers for the LCD text-mode glyph fetcher.
package lcd_fetch_sched_pkg;

    localparam int unsigned LCD_WIDTH = 640;
    localparam int unsigned LCD_HIGHT = 480;
    localparam int unsigned COLS      = 80;
    localparam int unsigned TEXT_ROWS = 30;
    localparam int unsigned GLYPH_H   = 16;

    // Bus widths shared by the interface and the datapath.
    localparam int unsigned ROW_W  = 10;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TXT_RD    = 3'd1,
        TXT_WAIT  = 3'd2,
        FONT_RD   = 3'd3,
        FONT_WAIT = 3'd4,
        PUSH      = 3'd5
    } fetch_state_t;

    // text_row * 80 without a multiplier: 64*r + 16*r.
    function automatic logic [ADDR_W-1:0] cols80_base(input logic [ADDR_W-1:0] text_row);
        return (text_row << 6) + (text_row << 4);
    endfunction

endpackage

// File: rtl/lcd_fetch_sched_if.sv
// Bundle of the fetcher's line request, FIFO, text RAM, font ROM and host write signals.
interface lcd_fetch_sched_if;
    import lcd_fetch_sched_pkg::*;

    // Line request
    logic              line_start;
    logic [ROW_W-1:0]  row;
    logic              busy;
    logic              overrun;

    // Pixel FIFO
    logic              fifo_full;
    logic              fifo_wr_en;
    logic [DATA_W-1:0] fifo_din;

    // Text RAM port
    logic [ADDR_W-1:0] txt_addr;
    logic              txt_we;
    logic [DATA_W-1:0] txt_wdata;
    logic [DATA_W-1:0] txt_rdata;

    // Font ROM port
    logic [ADDR_W-1:0] font_addr;
    logic [DATA_W-1:0] font_data;

    // Host write channel
    logic              host_req;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_data;
    logic              host_ack;

    // Fetcher side
    modport master (
        input  line_start, row, fifo_full, txt_rdata, font_data,
               host_req, host_addr, host_data,
        output fifo_wr_en, fifo_din, txt_addr, txt_we, txt_wdata,
               font_addr, host_ack, busy, overrun
    );

    // Environment side: timing generator, FIFO, memories and host
    modport slave (
        output line_start, row, fifo_full, txt_rdata, font_data,
               host_req, host_addr, host_data,
        input  fifo_wr_en, fifo_din, txt_addr, txt_we, txt_wdata,
               font_addr, host_ack, busy, overrun
    );

endinterface

// File: rtl/lcd_txt_arb.sv
// Text RAM single-port arbiter: the fetcher owns the port only during its read cycle,
// every other cycle is offered to a pending host write.
module lcd_txt_arb
    import lcd_fetch_sched_pkg::*;
(
    input  logic              rst,
    input  logic              fetch_own,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_data,
    output logic [ADDR_W-1:0] txt_addr,
    output logic              txt_we,
    output logic [DATA_W-1:0] txt_wdata,
    output logic              host_ack
);

    // Port mux; host is blocked while reset is held so the RAM sees no write strobe.
    always_comb begin
        txt_addr  = '0;
        txt_we    = 1'b0;
        txt_wdata = '0;
        host_ack  = 1'b0;
        if (fetch_own) begin
            txt_addr = fetch_addr;
        end else if (host_req && !rst) begin
            txt_addr  = host_addr;
            txt_we    = 1'b1;
            txt_wdata = host_data;
            host_ack  = 1'b1;
        end
    end

endmodule

// File: rtl/lcd_fetch_sched.sv
// Per-line glyph fetch scheduler: for each character of a text row it reads the
// character code, looks up the glyph line in the font ROM and pushes it to the pixel FIFO.
module lcd_fetch_sched #(
    parameter int unsigned COLS      = lcd_fetch_sched_pkg::COLS,
    parameter int unsigned TEXT_ROWS = lcd_fetch_sched_pkg::TEXT_ROWS,
    parameter int unsigned GLYPH_H   = lcd_fetch_sched_pkg::GLYPH_H
) (
    input  logic              pixel_clk,
    input  logic              rst,
    lcd_fetch_sched_if.master bus
);
    import lcd_fetch_sched_pkg::*;

    localparam int unsigned COL_W   = $clog2(COLS);
    localparam int unsigned GL_BITS = $clog2(GLYPH_H);

    fetch_state_t       state_q;
    logic [ADDR_W-1:0]  base_q;
    logic [GL_BITS-1:0] gl_q;
    logic [COL_W-1:0]   col_q;
    logic [ADDR_W-1:0]  font_addr_q;
    logic [DATA_W-1:0]  glyph_q;
    logic               overrun_q;

    logic [ADDR_W-1:0]  text_row;
    logic [ADDR_W-1:0]  base_d;
    logic [ADDR_W-1:0]  fetch_addr;
    logic               row_ok;
    logic               last_col;
    logic               fetch_own;

    // Line geometry decode for the incoming request and the current column.
    always_comb begin
        text_row   = ADDR_W'(bus.row >> GL_BITS);
        base_d     = (COLS == 80) ? cols80_base(text_row) : ADDR_W'(32'(text_row) * COLS);
        row_ok     = (32'(bus.row) < TEXT_ROWS * GLYPH_H);
        fetch_addr = base_q + ADDR_W'(col_q);
        last_col   = (32'(col_q) == COLS - 1);
        fetch_own  = (state_q == TXT_RD);
    end

    // Fetch FSM; a line_start always wins and restarts the line, aborting any work in flight.
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            gl_q        <= '0;
            col_q       <= '0;
            font_addr_q <= '0;
            glyph_q     <= '0;
            overrun_q   <= 1'b0;
        end else if (bus.line_start) begin
            if (state_q != IDLE) begin
                overrun_q <= 1'b1;
            end
            if (row_ok) begin
                base_q  <= base_d;
                gl_q    <= bus.row[GL_BITS-1:0];
                col_q   <= '0;
                state_q <= TXT_RD;
            end else begin
                state_q <= IDLE;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= IDLE;
                end
                TXT_RD: begin
                    state_q <= TXT_WAIT;
                end
                TXT_WAIT: begin
                    // Character code lands straight in the font address register.
                    font_addr_q <= ADDR_W'({bus.txt_rdata, gl_q});
                    state_q     <= FONT_RD;
                end
                FONT_RD: begin
                    state_q <= FONT_WAIT;
                end
                FONT_WAIT: begin
                    glyph_q <= bus.font_data;
                    state_q <= PUSH;
                end
                PUSH: begin
                    if (!bus.fifo_full) begin
                        if (last_col) begin
                            state_q <= IDLE;
                        end else begin
                            col_q   <= col_q + COL_W'(1);
                            state_q <= TXT_RD;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Push is combinational so a FIFO that drains mid-PUSH is served the same cycle;
    // a concurrent line_start suppresses it so an aborted line never leaks a glyph.
    assign bus.fifo_wr_en = (state_q == PUSH) && !bus.fifo_full && !bus.line_start;
    assign bus.fifo_din   = glyph_q;
    assign bus.font_addr  = font_addr_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.overrun    = overrun_q;

    lcd_txt_arb u_txt_arb (
        .rst        (rst),
        .fetch_own  (fetch_own),
        .fetch_addr (fetch_addr),
        .host_req   (bus.host_req),
        .host_addr  (bus.host_addr),
        .host_data  (bus.host_data),
        .txt_addr   (bus.txt_addr),
        .txt_we     (bus.txt_we),
        .txt_wdata  (bus.txt_wdata),
        .host_ack   (bus.host_ack)
    );

    // Host must never steal the fetcher's read slot.
    a_no_ack_in_rd : assert property (@(posedge pixel_clk) disable iff (rst)
        !(bus.host_ack && state_q == TXT_RD));

    // FIFO pushes only come out of PUSH.
    a_push_state : assert property (@(posedge pixel_clk) disable iff (rst)
        bus.fifo_wr_en |-> state_q == PUSH);

endmodule
